// File: rtl/cpu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: stores feed a TX FIFO,
// loads return status with one-cycle registered latency like the data RAM.
module cpu_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [3:0]  wen,
    input  logic [21:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [3:0]    cnt_field;
    logic [31:0]   status;

    logic push_req, clr_req, pop, full, empty, push_ok, baud_done;
    logic unused_bits;

    assign push_req  = sel & wen[0] & (addr[1:0] == 2'd0);
    assign clr_req   = sel & wen[0] & (addr[1:0] == 2'd1) & wdata[3];
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok   = push_req & (~full | pop);
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign unused_bits = ^{addr[21:2], wdata[31:8], wen[3:1]};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (clr_req)         overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_START;
            S_START: begin
                tx = 1'b0;
                if (baud_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx = shreg[bit_idx];
                if (baud_done && bit_idx == 3'd7) state_nxt = S_STOP;
            end
            S_STOP:  if (baud_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  baud_cnt <= '0;
            else if (state != S_IDLE) baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
            if (pop) shreg <= mem[rd_ptr];
            if (state == S_START)                 bit_idx <= '0;
            else if (state == S_DATA && baud_done) bit_idx <= bit_idx + 3'd1;
        end
    end

    // Count field is 4 bits wide; deeper FIFOs saturate rather than wrap
    always_comb begin
        if (32'(count) > 32'd15) cnt_field = 4'hF;
        else                     cnt_field = 4'(count);
    end

    assign status = {24'd0, cnt_field, overflow, empty, full, state != S_IDLE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= (addr[1:0] == 2'd1) ? status : 32'd0;
    end
endmodule

// File: tb/tb_cpu_uart_tx.sv
// Directed bench for cpu_uart_tx with a small UART receiver model on tx.
module tb_cpu_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  wen = '0;
    logic [21:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    cpu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wen(wen),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: detect start bit, sample each data bit mid-cell, keep frames with a good stop bit
    initial begin : rx_model
        logic [7:0] b;
        logic       stp;
        int         t0;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                b  = '0;
                repeat (2) @(posedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(posedge clk);
                    #1 b[j] = tx;
                end
                repeat (CPB) @(posedge clk);
                #1 stp = tx;
                if (stp === 1'b1) begin
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w, input logic s);
        addr = {20'd0, a}; wdata = d; wen = w; sel = s;
        @(posedge clk); #1;
        sel = 1'b0; wen = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = {20'd0, a};
        @(posedge clk); #1;
        v = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        idle(3);
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst_n = 1'b1;
        checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL post_reset_rdata got %h want 0", rdata); end
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL reset_status got %h want 00000004", v); end
        rd(2'd0, v);
        checks++; if (v !== 32'h0) begin errs++; $display("FAIL reset_data_rd got %h want 0", v); end
    endtask

    task automatic test_single();
        logic [7:0] byte_v;
        logic       exp_tx;
        int         bi;
        byte_v = 8'hA5;
        rx_q.delete(); rx_t.delete();
        wr(2'd0, 32'h0000_00A5, 4'b0001, 1'b1);
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL single_latency tx got %b want 1", tx); end
        addr = 22'd1;
        for (int k = 0; k < FRAME + 2; k++) begin
            @(posedge clk); #1;
            bi = k / CPB;
            if (k >= FRAME)   exp_tx = 1'b1;
            else if (bi == 0) exp_tx = 1'b0;
            else if (bi == 9) exp_tx = 1'b1;
            else              exp_tx = byte_v[bi-1];
            checks++; if (tx !== exp_tx) begin errs++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_tx); end
            if (k == 0) begin
                checks++; if (rdata !== 32'h10) begin errs++; $display("FAIL single_status0 got %h want 00000010", rdata); end
            end else if (k <= FRAME) begin
                checks++; if (rdata[0] !== 1'b1) begin errs++; $display("FAIL single_busy k=%0d got %b want 1", k, rdata[0]); end
            end else begin
                checks++; if (rdata !== 32'h4) begin errs++; $display("FAIL single_done_status got %h want 00000004", rdata); end
            end
        end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errs++; $display("FAIL single_rx got n=%0d want one byte a5", rx_q.size()); end
    endtask

    task automatic test_burst();
        logic [3:0]  cnt [100];
        logic [31:0] v;
        int          w;
        rx_q.delete(); rx_t.delete();
        for (int c = 0; c < 100; c++) begin
            if (c < 3) begin addr = 22'd0; sel = 1'b1; wen = 4'b0001; wdata = 32'(c + 1); end
            else       begin addr = 22'd1; sel = 1'b0; wen = 4'b0000; end
            @(posedge clk); #1;
            cnt[c] = rdata[7:4];
        end
        checks++; if (cnt[3] !== 4'd2) begin errs++; $display("FAIL burst_cnt_f1 got %0d want 2", cnt[3]); end
        checks++; if (cnt[43] !== 4'd1) begin errs++; $display("FAIL burst_cnt_f2 got %0d want 1", cnt[43]); end
        checks++; if (cnt[84] !== 4'd0) begin errs++; $display("FAIL burst_cnt_f3 got %0d want 0", cnt[84]); end
        w = 0;
        while (rx_q.size() < 3 && w < 200) begin idle(1); w++; end
        checks++;
        if (rx_q.size() != 3) begin
            errs++; $display("FAIL burst_frames got %0d want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[i] !== 8'(i + 1)) begin errs++; $display("FAIL burst_byte%0d got %h want %h", i, rx_q[i], 8'(i + 1)); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (rx_t[i] - rx_t[i-1] != FRAME + 1) begin errs++; $display("FAIL burst_gap%0d got %0d want %0d", i, rx_t[i] - rx_t[i-1], FRAME + 1); end
            end
        end
        idle(10);
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL burst_end_status got %h want 00000004", v); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        rx_q.delete(); rx_t.delete();
        wr(2'd0, 32'h0000_5500, 4'b0010, 1'b1);
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL lane_no_push got %h want 00000004", v); end
        wr(2'd0, 32'hFFFF_FF77, 4'hF, 1'b0);
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL nosel_no_push got %h want 00000004", v); end
        wr(2'd2, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wr(2'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL unmapped_wr got %h want 00000004", v); end
        rd(2'd2, v);
        checks++; if (v !== 32'h0) begin errs++; $display("FAIL rd_addr2 got %h want 0", v); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0) begin errs++; $display("FAIL rd_addr3 got %h want 0", v); end
        idle(5);
        checks++; if (tx !== 1'b1 || rx_q.size() != 0) begin errs++; $display("FAIL lanes_tx_idle got tx=%b n=%0d want tx=1 n=0", tx, rx_q.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int          w;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 10; i++) wr(2'd0, 32'(8'h11 + i), 4'b0001, 1'b1);
        rd(2'd1, v);
        checks++; if (v !== 32'h8B) begin errs++; $display("FAIL ovf_status got %h want 0000008b", v); end
        wr(2'd1, 32'h0808_0808, 4'b1110, 1'b1);
        rd(2'd1, v);
        checks++; if (v !== 32'h8B) begin errs++; $display("FAIL ovf_lane_clear got %h want 0000008b", v); end
        wr(2'd1, 32'h0000_0008, 4'b0001, 1'b1);
        rd(2'd1, v);
        checks++; if (v !== 32'h83) begin errs++; $display("FAIL ovf_clear got %h want 00000083", v); end
        w = 0;
        while (rx_q.size() < 9 && w < 600) begin idle(1); w++; end
        idle(80);
        checks++;
        if (rx_q.size() != 9) begin
            errs++; $display("FAIL ovf_frames got %0d want 9", rx_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (rx_q[i] !== 8'(8'h11 + i)) begin errs++; $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], 8'(8'h11 + i)); end
            end
        end
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL ovf_end_status got %h want 00000004", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int          lows;
        wr(2'd0, 32'h0000_0052, 4'b0001, 1'b1);
        wr(2'd0, 32'h0000_003C, 4'b0001, 1'b1);
        idle(17);
        checks++; if (tx !== 1'b0) begin errs++; $display("FAIL mid_bit3 got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL mid_async_tx got %b want 1", tx); end
        idle(2);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 150; k++) begin
            idle(1);
            if (tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errs++; $display("FAIL mid_no_frames got %0d low cycles want 0", lows); end
        rd(2'd1, v);
        checks++; if (v !== 32'h4) begin errs++; $display("FAIL mid_status got %h want 00000004", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_byte_lanes();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
